axis_frame_arbiter: RTL
=======================

Name: axis_frame_arbiter

Overview:
Packet-atomic round-robin arbiter that shares one downstream framer between N_CH byte-wide AXI4-Stream sources. It grants one source per packet, forwards that packet unbroken, and re-arbitrates only after the granted source's tlast beat has been accepted. It sits directly upstream of the framer, which adds start/stop delimiters around each forwarded packet.

Parameters:
N_CH, 4, number of source channels (2..16); localparam CH_W = max(1, $clog2(N_CH)).
CNT_W, 16, width of the completed-packet counter.

Ports:
aclk  input  1  clock.
aresetn  input  1  reset, asynchronous, active-low.
target_tvalid  input  N_CH  per-channel valid.
target_tready  output  N_CH  per-channel ready.
target_tdata  input  N_CH*8  channel c occupies bits [8c+7:8c].
target_tlast  input  N_CH  per-channel end of packet.
initiator_tvalid  output  1  registered valid to the framer.
initiator_tready  input  1  framer ready.
initiator_tdata  output  8  registered data.
initiator_tlast  output  1  registered end of packet.
grant_id  output  CH_W  currently or last granted channel.
busy  output  1  high while the arbiter is not in IDLE.
pkt_count  output  CNT_W  count of packets whose tlast beat has been accepted; wraps.

Behaviour:
- Reset values: initiator_tvalid=0, initiator_tdata=0, initiator_tlast=0, target_tready=0, grant_id=N_CH-1, busy=0, pkt_count=0, state=IDLE.
- Output stage: single register. It is loaded when "free" = !initiator_tvalid || initiator_tready. initiator_tvalid clears on accept if nothing new is loaded in that cycle.
- States: IDLE, HEADER (only with the optional feature), PASS.
- IDLE:
  - Search channels grant_id+1, grant_id+2, ... mod N_CH for the first with target_tvalid=1.
  - On a hit, register grant_id and go to HEADER or PASS. No data moves in this cycle.
  - With no requests, stay in IDLE.
- PASS:
  - target_tready[grant_id] = free (combinational). All other target_tready bits are 0.
  - On each source handshake, load the beat's tdata and tlast into the output register.
  - If the accepted beat has tlast=1: pkt_count++, go to IDLE.
- Latency: with the framer always ready and no optional feature, the first byte of a packet appears on initiator_tvalid 2 cycles after target_tvalid rises (arbitration cycle plus register). Subsequent beats stream at 1 per cycle.
- Re-arbitration costs exactly 1 bubble cycle between packets.
- Fairness:
  - If the same single channel is requesting, it is regranted back-to-back.
  - If all channels are requesting, the grant order is 0,1,2,3,0,... from reset.
- target_tvalid deasserting mid-packet: hold the grant and wait. There is no timeout.
- Single-beat packet (tlast on the first beat) is legal. It gives one output beat with tlast=1.
- Backpressure: initiator_tready low freezes the output register. No source beat is accepted and none is dropped or duplicated.
- Reset mid-packet: everything returns to reset values at once. A partially forwarded packet is truncated, and the downstream framer is reset by the same aresetn.
- pkt_count wraps from 2^CNT_W-1 to 0.

Optional Feature:
Macro FRAME_ARB_ID_BYTE_EN.
- When defined: after IDLE grants a channel, the arbiter enters HEADER. When the register is free, it loads initiator_tdata = {(8-CH_W) zeros, grant_id} with tlast=0, then goes to PASS. Every forwarded packet is thus prefixed by a channel-ID byte, and first-byte latency becomes 2 cycles (ID byte) and 3 cycles (first payload byte).
- When undefined: the HEADER state and its logic are absent, and packets pass unmodified.

Test Plan:
1. Reset, then ch1 sends 3 bytes A1,A2,A3 (tlast on A3) with framer ready -> output A1,A2,A3 on cycles 2,3,4 after tvalid; tlast only on A3; grant_id=1; pkt_count=1.
2. All 4 channels hold 2-byte packets at once -> packets emitted in order ch0,ch1,ch2,ch3,ch0; 1 idle cycle between packets; a non-granted channel never sees target_tready=1.
3. ch2 mid-packet, initiator_tready toggling 1010 and ch2 tvalid gapping -> output byte sequence identical to input; no duplicates; ch0 request ignored until ch2's tlast is accepted.
4. ch3 sends single-beat packet 0x55 with tlast, repeated 3 times with only ch3 requesting -> three outputs of 0x55 with tlast=1 each; grant stays 3; pkt_count=3.
5. aresetn pulsed low during beat 2 of a 4-byte packet -> all outputs at reset values the same cycle; after release, ch0 is granted first when all channels request.
6. With FRAME_ARB_ID_BYTE_EN, ch2 sends 0x10,0x11 -> output 0x02,0x10,0x11 with tlast only on 0x11.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// Packet-atomic round-robin arbiter: N_CH byte-wide AXI4-Stream sources share one registered output to the framer.
// Optional FRAME_ARB_ID_BYTE_EN prefixes every forwarded packet with a byte holding the granted channel number.
module axis_frame_arbiter #(
  parameter int  N_CH  = 4,
  parameter int  CNT_W = 16,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [N_CH-1:0]   target_tvalid,
  output logic [N_CH-1:0]   target_tready,
  input  logic [N_CH*8-1:0] target_tdata,
  input  logic [N_CH-1:0]   target_tlast,
  output logic              initiator_tvalid,
  input  logic              initiator_tready,
  output logic [7:0]        initiator_tdata,
  output logic              initiator_tlast,
  output logic [CH_W-1:0]   grant_id,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

`ifdef FRAME_ARB_ID_BYTE_EN
  typedef enum logic [1:0] {IDLE, HEADER, PASS} state_t;
`else
  typedef enum logic [1:0] {IDLE, PASS} state_t;
`endif

  state_t          state, state_nxt;
  logic [CH_W-1:0] grant_nxt;
  logic [CH_W-1:0] hit_id;
  logic            hit;
  int              idx;
  logic            free;
  logic            src_vld, src_last;
  logic [7:0]      src_dat;
  logic            load, load_last, cnt_inc;
  logic [7:0]      load_dat;

  // The output register may take a new beat when empty or being drained this cycle.
  assign free = !initiator_tvalid || initiator_tready;
  assign busy = (state != IDLE);

  always_comb begin
    src_vld  = 1'b0;
    src_dat  = '0;
    src_last = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant_id == CH_W'(c)) begin
        src_vld  = target_tvalid[c];
        src_dat  = target_tdata[c*8 +: 8];
        src_last = target_tlast[c];
      end
    end
  end

  // Rotating priority: the channel after the last grant is searched first.
  always_comb begin
    hit    = 1'b0;
    hit_id = grant_id;
    idx    = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(grant_id) + i) % N_CH;
      if (!hit && target_tvalid[CH_W'(idx)]) begin
        hit    = 1'b1;
        hit_id = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_id;
    target_tready = '0;
    load          = 1'b0;
    load_dat      = src_dat;
    load_last     = src_last;
    cnt_inc       = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          grant_nxt = hit_id;
`ifdef FRAME_ARB_ID_BYTE_EN
          state_nxt = HEADER;
`else
          state_nxt = PASS;
`endif
        end
      end
`ifdef FRAME_ARB_ID_BYTE_EN
      HEADER: begin
        if (free) begin
          load      = 1'b1;
          load_dat  = 8'(grant_id);
          load_last = 1'b0;
          state_nxt = PASS;
        end
      end
`endif
      PASS: begin
        for (int c = 0; c < N_CH; c++) begin
          target_tready[c] = free && (grant_id == CH_W'(c));
        end
        if (free && src_vld) begin
          load = 1'b1;
          if (src_last) begin
            cnt_inc   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      grant_id         <= CH_W'(N_CH - 1);
      initiator_tvalid <= 1'b0;
      initiator_tdata  <= '0;
      initiator_tlast  <= 1'b0;
      pkt_count        <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      if (load) begin
        initiator_tvalid <= 1'b1;
        initiator_tdata  <= load_dat;
        initiator_tlast  <= load_last;
      end else if (initiator_tready) begin
        initiator_tvalid <= 1'b0;
      end
      if (cnt_inc) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule
